// File: rtl/bcd_time_pkg.sv
// Shared types, limits and the load-validation helper for the BCD time keeper.
package bcd_time_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] MM_MAX = 8'h59;
  localparam logic [7:0] HH_MAX = 8'h23;

  // Ordering of valid BCD pairs matches their numeric order, so a plain compare bounds tens and ones together.
  function automatic logic bcd_pair_valid(input logic [7:0] pair, input logic [7:0] max);
    return (pair[3:0] <= 4'd9) && (pair[7:4] <= 4'd9) && (pair <= max);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping at MAX; carry is combinational so a chain advances in one edge.
module bcd_pair_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic at_max;

  assign at_max = (value == MAX);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (at_max) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= value + 8'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24-hour HH:MM:SS keeper in packed BCD, advanced by prescaler ticks, with run/pause/clear and checked load.
//
// state | meaning
// IDLE  | cleared or after reset; ticks ignored
// RUN   | ticks counted into sub-second counter and time
// PAUSE | time and sub-second count held; load accepted
module bcd_time_keeper
  import bcd_time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        set_en,
  input  logic [23:0] set_time,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        set_err
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  state_t           state, state_next;
  logic [SUB_W-1:0] sub, sub_next;
  logic             set_ok;
  logic             do_clear, do_load, do_err, adv;
  logic             ss_carry, mm_carry, hh_carry;

  assign set_ok = bcd_pair_valid(set_time[23:16], HH_MAX) &&
                  bcd_pair_valid(set_time[15:8],  MM_MAX) &&
                  bcd_pair_valid(set_time[7:0],   SS_MAX);

  // An invalid load in IDLE/PAUSE still consumes the cycle, so lower-priority commands wait.
  always_comb begin
    state_next = state;
    sub_next   = sub;
    do_clear   = 1'b0;
    do_load    = 1'b0;
    do_err     = 1'b0;
    adv        = 1'b0;
    if (clear) begin
      state_next = IDLE;
      sub_next   = '0;
      do_clear   = 1'b1;
    end else if (set_en && (state != RUN)) begin
      if (set_ok) begin
        do_load    = 1'b1;
        sub_next   = '0;
        state_next = PAUSE;
      end else begin
        do_err = 1'b1;
      end
    end else if (stop && (state == RUN)) begin
      state_next = PAUSE;
    end else if (start && (state != RUN)) begin
      state_next = RUN;
    end else if (tick && (state == RUN)) begin
      if (sub == SUB_LAST) begin
        sub_next = '0;
        adv      = 1'b1;
      end else begin
        sub_next = sub + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sub       <= '0;
      running   <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      state     <= state_next;
      sub       <= sub_next;
      running   <= (state_next == RUN);
      sec_pulse <= adv;
      day_wrap  <= hh_carry;
      set_err   <= do_err;
    end
  end

  bcd_pair_counter #(.MAX(SS_MAX)) u_ss (
    .clk      (clk),
    .reset    (reset),
    .clear    (do_clear),
    .load     (do_load),
    .load_val (set_time[7:0]),
    .inc      (adv),
    .value    (time_bcd[7:0]),
    .carry    (ss_carry)
  );

  bcd_pair_counter #(.MAX(MM_MAX)) u_mm (
    .clk      (clk),
    .reset    (reset),
    .clear    (do_clear),
    .load     (do_load),
    .load_val (set_time[15:8]),
    .inc      (ss_carry),
    .value    (time_bcd[15:8]),
    .carry    (mm_carry)
  );

  bcd_pair_counter #(.MAX(HH_MAX)) u_hh (
    .clk      (clk),
    .reset    (reset),
    .clear    (do_clear),
    .load     (do_load),
    .load_val (set_time[23:16]),
    .inc      (mm_carry),
    .value    (time_bcd[23:16]),
    .carry    (hh_carry)
  );

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed plus randomized bench; the reference keeps time as a seconds-of-day integer.
module tb_bcd_time_keeper;

  localparam int T = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        set_en = 1'b0;
  logic [23:0] set_time = 24'h0;
  logic [23:0] time_bcd;
  logic        running, sec_pulse, day_wrap, set_err;

  int checks = 0;
  int errors = 0;

  int   m_secs = 0;
  int   m_sub  = 0;
  int   m_mode = 0;  // 0 idle, 1 run, 2 pause
  logic e_sec = 1'b0, e_day = 1'b0, e_err = 1'b0;
  int   sp_cnt, dw_cnt, err_cnt;

  bcd_time_keeper #(.TICKS_PER_SEC(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .set_en    (set_en),
    .set_time  (set_time),
    .time_bcd  (time_bcd),
    .running   (running),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap),
    .set_err   (set_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int pair_val(input logic [7:0] p, input int lim);
    int t, o;
    t = int'(p[7:4]);
    o = int'(p[3:0]);
    if (o > 9 || t > 9 || (t * 10 + o) > lim) return -1;
    return t * 10 + o;
  endfunction

  task automatic model_step();
    int h, m, s;
    e_sec = 1'b0;
    e_day = 1'b0;
    e_err = 1'b0;
    h = pair_val(set_time[23:16], 23);
    m = pair_val(set_time[15:8], 59);
    s = pair_val(set_time[7:0], 59);
    if (reset) begin
      m_secs = 0; m_sub = 0; m_mode = 0;
    end else if (clear) begin
      m_secs = 0; m_sub = 0; m_mode = 0;
    end else if (set_en && m_mode != 1) begin
      if (h >= 0 && m >= 0 && s >= 0) begin
        m_secs = h * 3600 + m * 60 + s;
        m_sub  = 0;
        m_mode = 2;
      end else begin
        e_err = 1'b1;
      end
    end else if (stop && m_mode == 1) begin
      m_mode = 2;
    end else if (start && m_mode != 1) begin
      m_mode = 1;
    end else if (tick && m_mode == 1) begin
      m_sub = m_sub + 1;
      if (m_sub == T) begin
        m_sub  = 0;
        m_secs = (m_secs + 1) % 86400;
        e_sec  = 1'b1;
        e_day  = (m_secs == 0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("time_bcd", time_bcd, to_bcd(m_secs));
    chk("running", 24'(running), 24'(m_mode == 1));
    chk("sec_pulse", 24'(sec_pulse), 24'(e_sec));
    chk("day_wrap", 24'(day_wrap), 24'(e_day));
    chk("set_err", 24'(set_err), 24'(e_err));
    if (sec_pulse === 1'b1) sp_cnt++;
    if (day_wrap === 1'b1) dw_cnt++;
    if (set_err === 1'b1) err_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    set_time = v; set_en = 1'b1; cyc(); set_en = 1'b0;
  endtask

  initial begin
    sp_cnt = 0; dw_cnt = 0; err_cnt = 0;

    // 1: run from reset, four ticks = two seconds
    idle(2);
    reset = 1'b0;
    chk("t1_reset_time", time_bcd, 24'h000000);
    do_start();
    sp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      idle(9);
    end
    chk("t1_time", time_bcd, 24'h000002);
    chk("t1_sec_pulses", 24'(sp_cnt), 24'd2);
    chk("t1_running", 24'(running), 24'd1);

    // 2: day rollover
    do_clear();
    do_load(24'h235958);
    do_start();
    sp_cnt = 0; dw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      idle(2);
    end
    chk("t2_time", time_bcd, 24'h000000);
    chk("t2_day_wrap", 24'(dw_cnt), 24'd1);

    // 3: rejected and accepted loads in PAUSE
    do_stop();
    err_cnt = 0;
    do_load(24'h126000);
    do_load(24'h240000);
    do_load(24'h0A0000);
    chk("t3_errs", 24'(err_cnt), 24'd3);
    chk("t3_time_kept", time_bcd, 24'h000000);
    do_load(24'h125959);
    chk("t3_load", time_bcd, 24'h125959);
    chk("t3_no_err", 24'(err_cnt), 24'd3);

    // 4: tick dropped with stop; sub-count survives pause
    do_start();
    pulse_tick();
    tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
    chk("t4_no_adv", time_bcd, 24'h125959);
    chk("t4_paused", 24'(running), 24'd0);
    do_start();
    pulse_tick();
    chk("t4_resume", time_bcd, 24'h130000);

    // 5: tick dropped with clear; ticks outside RUN ignored
    do_clear();
    do_load(24'h010203);
    do_start();
    tick = 1'b1; clear = 1'b1; cyc(); clear = 1'b0;
    chk("t5_cleared", time_bcd, 24'h000000);
    chk("t5_no_pulse", 24'(sec_pulse), 24'd0);
    stop = 1'b1;
    idle(5);
    tick = 1'b0; stop = 1'b0;
    chk("t5_idle_time", time_bcd, 24'h000000);
    chk("t5_idle_run", 24'(running), 24'd0);

    // 6: reset during RUN, set_en ignored in RUN
    do_load(24'h000958);
    do_start();
    pulse_tick();
    pulse_tick();
    chk("t6_pre", time_bcd, 24'h000959);
    reset = 1'b1; tick = 1'b1; cyc(); reset = 1'b0; tick = 1'b0;
    chk("t6_reset_time", time_bcd, 24'h000000);
    chk("t6_reset_run", 24'(running), 24'd0);
    do_start();
    err_cnt = 0;
    do_load(24'h120000);
    chk("t6_run_load_ign", time_bcd, 24'h000000);
    chk("t6_run_load_err", 24'(err_cnt), 24'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      clear  = ($urandom_range(0, 149) == 0);
      tick   = ($urandom_range(0, 2) == 0);
      start  = ($urandom_range(0, 9) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      set_en = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 2))
        0: set_time = to_bcd(int'($urandom_range(0, 86399)));
        1: set_time = to_bcd(86400 - int'($urandom_range(1, 4)));
        default: set_time = 24'($urandom);
      endcase
      cyc();
    end
    reset = 1'b0; clear = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; set_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
